// File: rtl/fetch_ctrl.sv
// fetch_ctrl: run-control sequencer driving the fetch stage's init/halt/branch/target
//   Optional feature: define FETCH_CYCLE_COUNT_EN to build the saturating run-cycle counter;
//   when undefined CycleCount is tied to 0.
//   Ports:
//     CLK          system clock, rising edge
//     Init         synchronous active-high reset
//     Start        one-cycle pulse to begin or restart execution
//     HaltInstr    current instruction is halt
//     MemBusy      data memory not ready, instruction must not retire
//     BranchType   00 none, 01 always, 10 if ZeroFlag, 11 if !ZeroFlag
//     ZeroFlag     ALU zero flag
//     BranchOffset signed word offset
//     IfInit/IfHalt/IfBranch/IfTarget  fetch stage controls (combinational)
//     Busy/Done    run handshake
//     CycleCount   cycles spent in RUN
module fetch_ctrl #(
  parameter int INIT_CYCLES = 2,
  parameter int TGT_W       = 3,
  parameter int CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             Init,
  input  logic             Start,
  input  logic             HaltInstr,
  input  logic             MemBusy,
  input  logic [1:0]       BranchType,
  input  logic             ZeroFlag,
  input  logic [TGT_W-1:0] BranchOffset,
  output logic             IfInit,
  output logic             IfHalt,
  output logic             IfBranch,
  output logic [TGT_W-1:0] IfTarget,
  output logic             Busy,
  output logic             Done,
  output logic [CNT_W-1:0] CycleCount
);
  typedef enum logic [1:0] {S_IDLE, S_INIT, S_RUN, S_DONE} state_t;
  state_t     r_state;
  logic [3:0] r_icnt;
  logic       w_idle, w_init, w_run, w_done, w_stall, w_take, w_start_ok;
  assign w_idle     = r_state == S_IDLE;
  assign w_init     = r_state == S_INIT;
  assign w_run      = r_state == S_RUN;
  assign w_done     = r_state == S_DONE;
  // Halt outranks MemBusy; either one blocks the branch, which is re-evaluated next cycle
  assign w_stall    = HaltInstr | MemBusy;
  assign w_take     = (BranchType == 2'b01) | (BranchType == 2'b10 & ZeroFlag) | (BranchType == 2'b11 & ~ZeroFlag);
  assign w_start_ok = Start & (w_idle | w_done);
  assign IfInit     = w_idle | w_init;
  assign IfHalt     = w_idle | w_done | (w_run & w_stall);
  assign IfBranch   = w_run & ~w_stall & w_take;
  assign IfTarget   = IfBranch ? BranchOffset : '0;
  assign Busy       = w_init | w_run;
  assign Done       = w_done;
  always_ff @(posedge CLK) begin
    if (Init) begin
      r_state <= S_IDLE;
      r_icnt  <= '0;
    end else if (w_start_ok) begin
      r_state <= S_INIT;
      r_icnt  <= '0;
    end else if (w_init) begin
      r_icnt  <= r_icnt + 4'd1;
      r_state <= (r_icnt == 4'(INIT_CYCLES - 1)) ? S_RUN : S_INIT;
    end else if (w_run && HaltInstr) begin
      r_state <= S_DONE;
    end
  end
`ifdef FETCH_CYCLE_COUNT_EN
  logic [CNT_W-1:0] r_cnt;
  always_ff @(posedge CLK) begin
    if (Init || w_start_ok)
      r_cnt <= '0;
    else if (w_run && r_cnt != {CNT_W{1'b1}})
      r_cnt <= r_cnt + 1'b1;
  end
  assign CycleCount = r_cnt;
`else
  assign CycleCount = '0;
`endif
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: scoreboard bench for fetch_ctrl against an independent cycle model
module tb_fetch_ctrl;
  localparam int IC = 2;
  localparam int TW = 3;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;
  logic          CLK = 1'b0;
  logic          Init = 1'b1, Start = 1'b0, HaltInstr = 1'b0, MemBusy = 1'b0, ZeroFlag = 1'b0;
  logic [1:0]    BranchType = 2'b00;
  logic [TW-1:0] BranchOffset = '0;
  logic          IfInit, IfHalt, IfBranch, Busy, Done;
  logic [TW-1:0] IfTarget;
  logic [CW-1:0] CycleCount;
  fetch_ctrl #(.INIT_CYCLES(IC), .TGT_W(TW), .CNT_W(CW)) dut (
    .CLK(CLK), .Init(Init), .Start(Start), .HaltInstr(HaltInstr), .MemBusy(MemBusy),
    .BranchType(BranchType), .ZeroFlag(ZeroFlag), .BranchOffset(BranchOffset),
    .IfInit(IfInit), .IfHalt(IfHalt), .IfBranch(IfBranch), .IfTarget(IfTarget),
    .Busy(Busy), .Done(Done), .CycleCount(CycleCount)
  );
  always #5 CLK = ~CLK;
  typedef struct packed {
    logic          ii, ih, ib;
    logic [TW-1:0] it;
    logic          bu, dn;
    logic [CW-1:0] cc;
  } exp_t;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0;
  int m_st = 0, m_left = 0, m_cnt = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask
  task automatic step(input logic i, s, h, m, input logic [1:0] bt, input logic z, input logic [TW-1:0] off);
    exp_t e;
    bit stall, take;
    @(negedge CLK);
    Init = i; Start = s; HaltInstr = h; MemBusy = m; BranchType = bt; ZeroFlag = z; BranchOffset = off;
    stall = h | m;
    take = (bt == 2'd1) || (bt == 2'd2 && z) || (bt == 2'd3 && !z);
    e = '0;
    case (m_st)
      0: begin e.ii = 1; e.ih = 1; end
      1: begin e.ii = 1; e.bu = 1; end
      2: begin
        e.bu = 1;
        e.ih = stall;
        e.ib = !stall && take;
        e.it = e.ib ? off : '0;
      end
      default: begin e.ih = 1; e.dn = 1; end
    endcase
`ifdef FETCH_CYCLE_COUNT_EN
    e.cc = CW'(m_cnt);
`endif
    q.push_back(e);
    #2;
    e = q.pop_front();
    chk("IfInit", 32'(IfInit), 32'(e.ii));
    chk("IfHalt", 32'(IfHalt), 32'(e.ih));
    chk("IfBranch", 32'(IfBranch), 32'(e.ib));
    chk("IfTarget", 32'(IfTarget), 32'(e.it));
    chk("Busy", 32'(Busy), 32'(e.bu));
    chk("Done", 32'(Done), 32'(e.dn));
    chk("CycleCount", 32'(CycleCount), 32'(e.cc));
    @(posedge CLK);
    if (i) begin
      m_st = 0; m_cnt = 0;
    end else if ((m_st == 0 || m_st == 3) && s) begin
      m_st = 1; m_left = IC; m_cnt = 0;
    end else if (m_st == 1) begin
      m_left--;
      if (m_left == 0) m_st = 2;
    end else if (m_st == 2) begin
      if (m_cnt < CMAX) m_cnt++;
      if (h) m_st = 3;
    end
  endtask
  initial begin
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 1, 0, 3);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 1, 0, 2);
    step(0, 0, 0, 0, 2, 1, 1);
    step(0, 0, 0, 0, 2, 0, 1);
    step(0, 0, 0, 0, 3, 0, 5);
    step(0, 0, 0, 0, 3, 1, 5);
    step(0, 0, 0, 0, 0, 0, 7);
    step(0, 1, 0, 0, 1, 0, 2);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 1, 1, 0, 7);
    step(0, 0, 0, 0, 1, 0, 7);
    step(0, 0, 1, 1, 1, 1, 3);
    step(0, 0, 1, 1, 1, 0, 4);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 21; k++) step(0, 0, 0, k[0], 2'(k), k[1], 3'(k));
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 1, 0, 6);
    step(1, 1, 0, 0, 1, 0, 6);
    step(0, 0, 0, 0, 1, 0, 6);
    for (int k = 0; k < 300; k++)
      step($urandom_range(31) == 0, $urandom_range(7) == 0, $urandom_range(15) == 0,
           $urandom_range(3) == 0, 2'($urandom), 1'($urandom), TW'($urandom));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
